mac_accum: RTL and testbench

Signed multiply-accumulate back end for the 8x8 two's-complement array multiplier. It registers the multiplier's 16-bit product, which retimes the combinational array. It then sums a frame of products into a wide signed accumulator and presents the frame total on a valid/ready output. It sits directly downstream of the multiplier, and its `in_prod` connects to the multiplier's product bus.

---
 rtl/mac_accum.sv | 166 ++++++++++++++++
 tb/tb_mac_accum.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accum.sv
`default_nettype none
// ============================================================================
// Module      : mac_accum
// Description : Registers the 8x8 multiplier's signed product, then sums each
//               frame into an ACC_W-bit accumulator with a valid/ready result.
//               Define MAC_SAT_EN to saturate on overflow instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_accum #(
  parameter int ACC_W   = 24,
  parameter int MAX_LEN = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [7:0]       out_cnt,
  output logic             out_ovf
);

  typedef enum logic [0:0] {ST_ACC = 1'b0, ST_DONE = 1'b1} state_t;

  localparam logic [ACC_W-1:0] C_SAT_POS = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] C_SAT_NEG = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [7:0]       C_MAX_LEN = 8'(MAX_LEN);

  state_t           state_q, state_d;
  logic [15:0]      p_q, p_d;
  logic             p_v_q, p_v_d;
  logic             p_last_q, p_last_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_acc_q, out_acc_d;
  logic [7:0]       out_cnt_q, out_cnt_d;
  logic             out_ovf_q, out_ovf_d;

  logic             w_in_fire;
  logic             w_consume;
  logic             w_add_ovf;
  logic             w_close;
  logic [ACC_W-1:0] w_addend;
  logic [ACC_W-1:0] w_raw_sum;
  logic [ACC_W-1:0] w_sum;
  logic [7:0]       w_cnt_inc;

  assign in_ready  = !p_v_q || (state_q == ST_ACC);
  assign w_in_fire = in_valid && in_ready;
  assign w_consume = p_v_q && (state_q == ST_ACC);

  assign w_addend  = {{(ACC_W-16){p_q[15]}}, p_q};
  assign w_raw_sum = acc_q + w_addend;
  // Same-sign addends producing an opposite-sign result is signed overflow.
  assign w_add_ovf = (acc_q[ACC_W-1] == p_q[15]) && (w_raw_sum[ACC_W-1] != acc_q[ACC_W-1]);
  assign w_cnt_inc = cnt_q + 8'd1;
  assign w_close   = p_last_q || (w_cnt_inc == C_MAX_LEN);

`ifdef MAC_SAT_EN
  assign w_sum = w_add_ovf ? (acc_q[ACC_W-1] ? C_SAT_NEG : C_SAT_POS) : w_raw_sum;
`else
  assign w_sum = w_raw_sum;
`endif

  always_comb begin
    p_d      = p_q;
    p_v_d    = p_v_q;
    p_last_d = p_last_q;
    if (w_consume) begin
      p_v_d = 1'b0;
    end
    if (w_in_fire) begin
      p_d      = in_prod;
      p_last_d = in_last;
      p_v_d    = 1'b1;
    end
    if (clr) begin
      p_v_d = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_cnt_d   = out_cnt_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      ST_ACC: begin
        if (p_v_q) begin
          acc_d = w_sum;
          cnt_d = w_cnt_inc;
          ovf_d = ovf_q | w_add_ovf;
          if (w_close) begin
            out_acc_d   = w_sum;
            out_cnt_d   = w_cnt_inc;
            out_ovf_d   = ovf_q | w_add_ovf;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_valid_q && out_ready) begin
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          out_valid_d = 1'b0;
          state_d     = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
    if (clr) begin
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
      state_d     = ST_ACC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      p_q         <= '0;
      p_v_q       <= 1'b0;
      p_last_q    <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_cnt_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      p_v_q       <= p_v_d;
      p_last_q    <= p_last_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_cnt_q   <= out_cnt_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_cnt   = out_cnt_q;
  assign out_ovf   = out_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_accum
// Description : Scoreboard bench driving a 24-bit and a 17-bit mac_accum with
//               identical stimulus; honours MAC_SAT_EN in its reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_accum;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        clr       = 1'b0;
  logic        in_valid  = 1'b0;
  logic        in_last   = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in_prod   = '0;

  logic        in_ready,  out_valid,  out_ovf;
  logic [23:0] out_acc;
  logic [7:0]  out_cnt;
  logic        in_ready17, out_valid17, out_ovf17;
  logic [16:0] out_acc17;
  logic [7:0]  out_cnt17;

  int n_checks = 0;
  int n_fail   = 0;
  bit stall_seen = 1'b0;

  always #5 clk = ~clk;

  mac_accum #(.ACC_W(24), .MAX_LEN(255)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_cnt(out_cnt), .out_ovf(out_ovf)
  );

  mac_accum #(.ACC_W(17), .MAX_LEN(255)) dut17 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready17), .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid17), .out_ready(out_ready),
    .out_acc(out_acc17), .out_cnt(out_cnt17), .out_ovf(out_ovf17)
  );

  typedef struct {
    longint acc24;
    longint acc17;
    int     cnt;
    bit     ovf24;
    bit     ovf17;
  } exp_t;

  exp_t   sb_q[$];
  longint m_acc24 = 0;
  longint m_acc17 = 0;
  int     m_cnt   = 0;
  bit     m_ovf24 = 1'b0;
  bit     m_ovf17 = 1'b0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic bit in_range(input longint v, input int w);
    return (v >= -(longint'(1) <<< (w-1))) && (v < (longint'(1) <<< (w-1)));
  endfunction

  function automatic longint fold(input longint v, input int w);
    longint half = longint'(1) <<< (w-1);
    if (in_range(v, w)) return v;
`ifdef MAC_SAT_EN
    return (v > 0) ? half - 1 : -half;
`else
    return (v > 0) ? v - 2*half : v + 2*half;
`endif
  endfunction

  task automatic model_reset();
    m_acc24 = 0; m_acc17 = 0; m_cnt = 0; m_ovf24 = 1'b0; m_ovf17 = 1'b0;
  endtask

  task automatic model_accept(input logic [15:0] p, input logic last);
    longint pv  = longint'($signed(p));
    longint s24 = m_acc24 + pv;
    longint s17 = m_acc17 + pv;
    exp_t   e;
    if (!in_range(s24, 24)) m_ovf24 = 1'b1;
    if (!in_range(s17, 17)) m_ovf17 = 1'b1;
    m_acc24 = fold(s24, 24);
    m_acc17 = fold(s17, 17);
    m_cnt++;
    if (last || m_cnt == 255) begin
      e.acc24 = m_acc24; e.acc17 = m_acc17; e.cnt = m_cnt;
      e.ovf24 = m_ovf24; e.ovf17 = m_ovf17;
      sb_q.push_back(e);
      model_reset();
    end
  endtask

  // Present one product and return just after the edge that accepts it.
  task automatic send(input int p, input logic last);
    int waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_prod  = p[15:0];
    in_last  = last;
    while (!in_ready && waited < 200) begin
      stall_seen = 1'b1;
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check_eq("in_ready_timeout", longint'(in_ready), 1);
    end else begin
      model_accept(in_prod, in_last);
      @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Result monitor: pops on handshake and checks held results stay put.
  logic [23:0] prev_acc;
  logic [7:0]  prev_cnt;
  logic        prev_ovf;
  bit          prev_hold = 1'b0;

  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (prev_hold) begin
        check_eq("hold_valid", longint'(out_valid), 1);
        check_eq("hold_acc",   longint'(out_acc),   longint'(prev_acc));
        check_eq("hold_cnt",   longint'(out_cnt),   longint'(prev_cnt));
        check_eq("hold_ovf",   longint'(out_ovf),   longint'(prev_ovf));
      end
      if (out_valid && out_ready) begin
        check_eq("sb_nonempty", longint'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check_eq("acc24",   longint'(out_acc),   e.acc24 & 64'hFF_FFFF);
          check_eq("cnt24",   longint'(out_cnt),   longint'(e.cnt));
          check_eq("ovf24",   longint'(out_ovf),   longint'(e.ovf24));
          check_eq("valid17", longint'(out_valid17), 1);
          check_eq("acc17",   longint'(out_acc17), e.acc17 & 64'h1_FFFF);
          check_eq("cnt17",   longint'(out_cnt17), longint'(e.cnt));
          check_eq("ovf17",   longint'(out_ovf17), longint'(e.ovf17));
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_acc  = out_acc;
      prev_cnt  = out_cnt;
      prev_ovf  = out_ovf;
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    bit rand_done = 1'b0;
    int waited    = 0;

    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_in_ready",   longint'(in_ready),   1);
    check_eq("rst_in_ready17", longint'(in_ready17), 1);
    check_eq("rst_out_valid",  longint'(out_valid),  0);
    check_eq("rst_out_acc",    longint'(out_acc),    0);
    check_eq("rst_out_cnt",    longint'(out_cnt),    0);
    check_eq("rst_out_ovf",    longint'(out_ovf),    0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame and result latency
    send(100, 1'b0);
    send(-50, 1'b0);
    send(7,   1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check_eq("lat_before", longint'(out_valid), 0);
    @(negedge clk);
    #1 check_eq("lat_after",  longint'(out_valid), 1);
    idle(3);

    // Backpressure: frame 2 streams while frame 1 is held
    send(10, 1'b0);
    send(20, 1'b1);
    @(negedge clk);
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    stall_seen = 1'b0;
    fork
      begin
        repeat (6) @(negedge clk);
        out_ready = 1'b1;
      end
      begin
        send(1, 1'b0);
        send(2, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
      end
    join
    check_eq("bp_in_ready_dropped", longint'(stall_seen), 1);
    idle(4);

    // Overflow (observed on the 17-bit instance)
    send(32767, 1'b0);
    send(32767, 1'b0);
    send(32767, 1'b1);
    idle(4);

    // Forced close at MAX_LEN, then a fresh single-product frame
    for (int i = 0; i < 255; i++) send(1, 1'b0);
    send(1, 1'b1);
    idle(4);

    // Sign extension of the most negative product
    send(32'h8000, 1'b1);
    idle(4);

    // Abort via clr mid-frame
    send(3, 1'b0);
    send(4, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    clr      = 1'b1;
    model_reset();
    @(negedge clk);
    clr = 1'b0;
    send(5, 1'b1);
    idle(4);

    // Random frames with random gaps and random consumer backpressure
    fork
      begin
        while (!rand_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 1) == 1);
        end
        out_ready = 1'b1;
      end
      begin
        for (int f = 0; f < 20; f++) begin
          int len = $urandom_range(1, 5);
          for (int k = 0; k < len; k++) begin
            send(int'($urandom_range(0, 65535)), (k == len - 1));
            if ($urandom_range(0, 3) == 0) idle(1);
          end
        end
        idle(1);
        rand_done = 1'b1;
      end
    join
    idle(30);

    // Asynchronous reset between edges while a result is held
    out_ready = 1'b0;
    send(5, 1'b0);
    send(6, 1'b1);
    idle(3);
    send(9, 1'b0);
    @(negedge clk);
    check_eq("pre_rst_acc", longint'(out_acc), 11);
    #1 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("arst_in_ready",  longint'(in_ready),  1);
    check_eq("arst_out_valid", longint'(out_valid), 0);
    check_eq("arst_out_acc",   longint'(out_acc),   0);
    check_eq("arst_out_cnt",   longint'(out_cnt),   0);
    check_eq("arst_out_ovf",   longint'(out_ovf),   0);
    sb_q.delete();
    model_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(5, 1'b1);
    idle(1);

    while (sb_q.size() > 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    idle(2);
    check_eq("drain_empty", longint'(sb_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
